word_adder_sched: RTL
=====================

WORD_ADDER_SCHED -- requirements
Module: word_adder_sched

Interface
REQ-001 Parameter NUM_REQ, 2: number of requesters sharing one word adder; legal range 2..8.
REQ-002 Parameter ADDER_LAT, 1: adder cycles from enable to valid add_result; legal range 1..15.
REQ-003 Derived ID_W = clog2(NUM_REQ): response-tag width.
REQ-004 Clock and reset are fixed: a single clock, clk, and a reset, rst, that SHALL be synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester command valid.
REQ-008 req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-009 req_func  in  2*NUM_REQ  packed adder func per requester; slice i belongs to requester i.
REQ-010 req_word  in  9*NUM_REQ  packed 9-bit operand per requester.
REQ-011 rsp_valid  out  1  response valid.
REQ-012 rsp_ready  in  1  response consumer ready.
REQ-013 rsp_id  out  ID_W  index of the requester that owns the response.
REQ-014 rsp_result  out  9  captured adder result.
REQ-015 add_func  out  2  func to the adder.
REQ-016 add_inWord  out  9  operand to the adder.
REQ-017 add_enable  out  1  one-cycle start pulse to the adder.
REQ-018 add_result  in  9  adder result.
REQ-019 busy  out  1  high in every state other than IDLE.

Function
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE: when any req_valid is high, the arbiter selects one requester i and asserts req_ready[i] combinationally in the same cycle. The block latches req_func and req_word slices i plus the ID, then moves to ISSUE.
REQ-022 ISSUE: add_enable is high for exactly this one cycle, the wait counter loads ADDER_LAT, and the FSM moves to WAIT.
REQ-023 WAIT: the counter decrements each cycle. In the cycle it reaches 1, add_result is captured into rsp_result and the FSM moves to RESP. WAIT therefore lasts exactly ADDER_LAT cycles.
REQ-024 RESP: rsp_valid is high. rsp_id and rsp_result are held stable until rsp_valid and rsp_ready are both high; the FSM then returns to IDLE.
REQ-025 Latency: acceptance in cycle t gives add_enable in cycle t+1 and first rsp_valid in cycle t+2+ADDER_LAT.
REQ-026 add_func and add_inWord hold the latched command from ISSUE through RESP. They are 0 in IDLE.
REQ-027 req_ready is 0 in every state except IDLE. A new request in the same cycle as the response handshake waits and is accepted no earlier than the next cycle.
REQ-028 Throughput is one command per ADDER_LAT+3 cycles when rsp_ready is held high.
REQ-029 A requester that drops req_valid before it is granted is simply not served; no state changes.
REQ-030 Width rule: no arithmetic is done on data; all 9-bit values pass through unmodified.
REQ-031 The wait counter is 4 bits wide and never wraps; the FSM leaves WAIT at count 1.

Reset
REQ-032 While rst is high, the FSM SHALL enter IDLE and all outputs SHALL be 0: req_ready, rsp_valid, rsp_id, rsp_result, add_func, add_inWord, add_enable and busy.
REQ-033 Reset also sets the round-robin pointer to 0 and clears the counter.
REQ-034 Reset in the middle of an operation abandons the in-flight command: no response is produced and the requester is not re-granted automatically.

Configuration
REQ-035 Macro WORD_ADDER_SCHED_RR_EN, when defined, SHALL give round-robin arbitration: after granting i, the search starts at i+1 modulo NUM_REQ, and the pointer updates only on a grant.
REQ-036 When WORD_ADDER_SCHED_RR_EN is undefined, arbitration SHALL be fixed priority, with the lowest index winning, and no pointer register is built.

Structure
REQ-037 The shared package word_adder_sched_pkg SHALL hold the state enum, FUNC_W=2, WORD_W=9 and the default ADDER_LAT.
REQ-038 The arbiter SHALL be a separate sub-module, word_adder_sched_arb, taking request, pointer and enable inputs and producing a one-hot grant.

Verification
REQ-039 Single command, ADDER_LAT=1: req_valid[0]=1, func=2'b01, word=9'h0A1; add_result=9'h055 driven during WAIT -> enable at t+1, then rsp_valid at t+3 with rsp_id=0 and rsp_result=9'h055.
REQ-040 Contention with RR_EN defined: both requesters always valid -> grants alternate 0,1,0,1 and responses carry IDs in the same order.
REQ-041 Contention with RR_EN undefined: both requesters always valid -> requester 0 is granted on every command and requester 1 starves.
REQ-042 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id and rsp_result stay stable, req_ready stays 0, and a new grant follows the cycle after rsp_ready=1.
REQ-043 Reset mid-WAIT with ADDER_LAT=4: rst pulses in the 2nd WAIT cycle -> the following cycle is IDLE with all outputs 0 and no rsp_valid ever appears for the abandoned command.
REQ-044 ADDER_LAT=15: exactly 15 WAIT cycles are counted before capture.

Source files
------------

// File: rtl/word_adder_sched_pkg.sv
// Shared types and constants for the word adder scheduler.
package word_adder_sched_pkg;
  localparam int FUNC_W        = 2;
  localparam int WORD_W        = 9;
  localparam int DEF_ADDER_LAT = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/word_adder_sched_if.sv
// Request/response/adder bundle between the scheduler (slave) and its environment (master).
interface word_adder_sched_if
  import word_adder_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][FUNC_W-1:0] req_func;
  logic [NUM_REQ-1:0][WORD_W-1:0] req_word;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_W-1:0]                rsp_id;
  logic [WORD_W-1:0]              rsp_result;
  logic [FUNC_W-1:0]              add_func;
  logic [WORD_W-1:0]              add_inWord;
  logic                           add_enable;
  logic [WORD_W-1:0]              add_result;
  logic                           busy;

  modport master (
    output req_valid, req_func, req_word, rsp_ready, add_result,
    input  req_ready, rsp_valid, rsp_id, rsp_result, add_func, add_inWord, add_enable, busy
  );

  modport slave (
    input  req_valid, req_func, req_word, rsp_ready, add_result,
    output req_ready, rsp_valid, rsp_id, rsp_result, add_func, add_inWord, add_enable, busy
  );
endinterface

// File: rtl/word_adder_sched_arb.sv
// One-hot requester arbiter. WORD_ADDER_SCHED_RR_EN selects round-robin from ptr;
// otherwise fixed priority with the lowest index winning.
module word_adder_sched_arb #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt
);
`ifdef WORD_ADDER_SCHED_RR_EN
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (enable && !found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/word_adder_sched.sv
// Shares one multi-cycle word adder among NUM_REQ requesters: IDLE -> ISSUE -> WAIT -> RESP.
// Define WORD_ADDER_SCHED_RR_EN for round-robin arbitration (fixed priority otherwise).
module word_adder_sched
  import word_adder_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDER_LAT = DEF_ADDER_LAT
) (
  input logic               clk,
  input logic               rst,
  word_adder_sched_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id, ptr, id_q;
  logic [FUNC_W-1:0]  func_q;
  logic [WORD_W-1:0]  word_q, res_q;
  logic [3:0]         cnt;
  logic               arb_en;

  assign arb_en = (state == IDLE) && !rst;

  word_adder_sched_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .enable (arb_en),
    .gnt    (gnt)
  );

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_id = ID_W'(i);
  end

`ifdef WORD_ADDER_SCHED_RR_EN
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (|gnt)
      ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Combinational outputs are forced low while rst is asserted, not just after the edge.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.add_enable = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.busy       = 1'b0;
    if (!rst) begin
      bus.busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          bus.req_ready = gnt;
          if (|gnt) state_nxt = ISSUE;
        end
        ISSUE: begin
          bus.add_enable = 1'b1;
          state_nxt      = WAIT;
        end
        WAIT: if (cnt == 4'd1) state_nxt = RESP;
        RESP: begin
          bus.rsp_valid = 1'b1;
          if (bus.rsp_ready) state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q   <= '0;
      func_q <= '0;
      word_q <= '0;
      res_q  <= '0;
      cnt    <= '0;
    end else begin
      if (state == IDLE && |gnt) begin
        id_q   <= gnt_id;
        func_q <= bus.req_func[gnt_id];
        word_q <= bus.req_word[gnt_id];
      end
      if (state == ISSUE) cnt <= 4'(ADDER_LAT);
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) res_q <= bus.add_result;
      end
    end
  end

  assign bus.add_func   = (state != IDLE && !rst) ? func_q : '0;
  assign bus.add_inWord = (state != IDLE && !rst) ? word_q : '0;
  assign bus.rsp_id     = rst ? '0 : id_q;
  assign bus.rsp_result = rst ? '0 : res_q;
endmodule
